// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/EXEC/LDWB/HALT sequencer for a 16-bit
// instruction set. Holds PC and IR and decodes datapath control from them.
module control_unit #(
    parameter logic [5:0] PC_RESET = 6'd0
) (
    input  logic        clk_main,
    input  logic        reset,
    input  logic [15:0] InstrIn,
    input  logic        Z,
    output logic [5:0]  PC,
    output logic [3:0]  DR,
    output logic [3:0]  SA,
    output logic [3:0]  SB,
    output logic [3:0]  FS,
    output logic [15:0] ConstOut,
    output logic        MB,
    output logic        MM,
    output logic        MD,
    output logic        RW,
    output logic        MW,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        LDWB  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI = 4'hC;
    localparam logic [3:0] OP_LD  = 4'hD;
    localparam logic [3:0] OP_ST  = 4'hE;
    localparam logic [3:0] OP_BR  = 4'hF;

    localparam logic [3:0] BR_JMP = 4'h0;
    localparam logic [3:0] BR_BZ  = 4'h1;
    localparam logic [3:0] BR_BNZ = 4'h2;
    localparam logic [3:0] BR_HLT = 4'hF;

    state_t      state;
    state_t      state_nx;
    logic [15:0] ir;
    logic [5:0]  pc_nx;
    logic [3:0]  op;
    logic [3:0]  sub;
    logic [5:0]  br_off;

    assign op     = ir[15:12];
    assign sub    = ir[11:8];
    // Branch displacement is IR[3:0] sign-extended to the PC width.
    assign br_off = {{2{ir[3]}}, ir[3:0]};

    // State, PC and IR registers; reset aborts any instruction in flight.
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            PC    <= PC_RESET;
            ir    <= '0;
        end else begin
            state <= state_nx;
            PC    <= pc_nx;
            if (state == FETCH) begin
                ir <= InstrIn;
            end
        end
    end

    // Next state and next PC; branch decision samples Z directly in EXEC.
    always_comb begin
        state_nx = state;
        pc_nx    = PC;
        case (state)
            FETCH: begin
                state_nx = EXEC;
                pc_nx    = PC + 6'd1;
            end
            EXEC: begin
                if (op == OP_LD) begin
                    state_nx = LDWB;
                end else if (op == OP_BR && sub == BR_HLT) begin
                    state_nx = HALT;
                end else begin
                    state_nx = FETCH;
                end
                if (op == OP_BR) begin
                    case (sub)
                        BR_JMP:  pc_nx = ir[5:0];
                        BR_BZ:   if (Z)  pc_nx = PC + br_off;
                        BR_BNZ:  if (!Z) pc_nx = PC + br_off;
                        default: pc_nx = PC;
                    endcase
                end
            end
            LDWB:    state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    // Moore decode of datapath controls from state and IR.
    always_comb begin
        DR       = ir[11:8];
        SA       = ir[7:4];
        SB       = ir[3:0];
        ConstOut = {12'h000, ir[3:0]};
        FS       = (op == OP_BR) ? 4'h0 : op;
        MB       = 1'b0;
        MM       = 1'b0;
        MD       = 1'b0;
        RW       = 1'b0;
        MW       = 1'b0;
        halted   = (state == HALT);
        case (state)
            EXEC: begin
                if (op <= OP_LDI) RW = 1'b1;
                if (op == OP_LDI) MB = 1'b1;
                if (op == OP_ST)  MW = 1'b1;
            end
            LDWB: begin
                MD = 1'b1;
                RW = 1'b1;
            end
            default: begin
                RW = 1'b0;
                MW = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: instruction-level reference model plus directed literal
// checks and randomized programs with asynchronous resets.
module tb_control_unit;

    localparam logic [5:0] PCR = 6'd0;

    logic        clk_main = 1'b0;
    logic        reset    = 1'b0;
    logic [15:0] InstrIn;
    logic        Z        = 1'b0;
    logic [5:0]  PC;
    logic [3:0]  DR, SA, SB, FS;
    logic [15:0] ConstOut;
    logic        MB, MM, MD, RW, MW, halted;

    logic [15:0] imem [64];
    assign InstrIn = imem[PC];

    control_unit #(.PC_RESET(PCR)) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .InstrIn  (InstrIn),
        .Z        (Z),
        .PC       (PC),
        .DR       (DR),
        .SA       (SA),
        .SB       (SB),
        .FS       (FS),
        .ConstOut (ConstOut),
        .MB       (MB),
        .MM       (MM),
        .MD       (MD),
        .RW       (RW),
        .MW       (MW),
        .halted   (halted)
    );

    always #5 clk_main = ~clk_main;

    int checks = 0;
    int errors = 0;

    // Reference model: instruction word, PC, and which cycle of the
    // instruction we are in (0 = fetch, 1 = execute, 2 = load writeback).
    int          m_pc;
    logic [15:0] m_ir;
    int          m_step;
    bit          m_halt;
    bit          z_force = 1'b0;
    bit          z_val   = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc   = int'(PCR);
        m_ir   = '0;
        m_step = 0;
        m_halt = 1'b0;
    endfunction

    // Advance the model on each clock edge with the same Z/InstrIn the DUT sees.
    always @(posedge clk_main) begin
        int op, sub, off;
        if (reset && !m_halt) begin
            if (m_step == 0) begin
                m_ir   = imem[m_pc];
                m_pc   = (m_pc + 1) % 64;
                m_step = 1;
            end else if (m_step == 2) begin
                m_step = 0;
            end else begin
                op  = int'(m_ir[15:12]);
                sub = int'(m_ir[11:8]);
                off = int'(m_ir[3:0]);
                if (off > 7) off = off - 16;
                m_step = 0;
                if (op == 13) begin
                    m_step = 2;
                end else if (op == 15) begin
                    if (sub == 15)      m_halt = 1'b1;
                    else if (sub == 0)  m_pc = int'(m_ir[5:0]);
                    else if ((sub == 1 && Z) || (sub == 2 && !Z))
                        m_pc = (m_pc + off + 64) % 64;
                end
            end
        end
    end

    // Compare DUT to model every cycle, then drive the next Z.
    always @(negedge clk_main) begin
        int op, sub;
        int erw, emw, emb, emd;
        if (reset) begin
            op  = int'(m_ir[15:12]);
            sub = int'(m_ir[11:8]);
            erw = 0; emw = 0; emb = 0; emd = 0;
            if (!m_halt && m_step == 1) begin
                if (op <= 12) erw = 1;
                if (op == 12) emb = 1;
                if (op == 14) emw = 1;
                if (op <= 12) chk("m_fs", int'(FS), op);
                if (op == 15 && (sub == 1 || sub == 2)) chk("m_fs_br", int'(FS), 0);
            end
            if (!m_halt && m_step == 2) begin
                erw = 1;
                emd = 1;
            end
            chk("m_pc",     int'(PC),       m_pc);
            chk("m_halted", int'(halted),   int'(m_halt));
            chk("m_dr",     int'(DR),       int'(m_ir[11:8]));
            chk("m_sa",     int'(SA),       int'(m_ir[7:4]));
            chk("m_sb",     int'(SB),       int'(m_ir[3:0]));
            chk("m_const",  int'(ConstOut), int'(m_ir[3:0]));
            chk("m_rw",     int'(RW),       erw);
            chk("m_mw",     int'(MW),       emw);
            chk("m_mb",     int'(MB),       emb);
            chk("m_md",     int'(MD),       emd);
            chk("m_mm",     int'(MM),       0);
        end
        Z = z_force ? z_val : 1'($urandom_range(0, 1));
    end

    // Assert reset d time units into the low clock phase and verify it acts
    // without a clock edge.
    task automatic rst_assert(input int d);
        #(d);
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_pc",     int'(PC),     int'(PCR));
        chk("rst_rw",     int'(RW),     0);
        chk("rst_mw",     int'(MW),     0);
        chk("rst_mb",     int'(MB),     0);
        chk("rst_md",     int'(MD),     0);
        chk("rst_halted", int'(halted), 0);
    endtask

    task automatic rst_release();
        @(negedge clk_main);
        #2;
        reset = 1'b1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 64; i++) imem[i] = 16'hF300;
    endtask

    initial begin
        fill_nop();
        model_reset();
        rst_assert(2);

        // ALU instruction
        imem[0] = 16'h3123;
        imem[1] = 16'hFF00;
        rst_release();
        @(negedge clk_main);
        chk("alu_pc", int'(PC), 1);
        chk("alu_fs", int'(FS), 3);
        chk("alu_dr", int'(DR), 1);
        chk("alu_sa", int'(SA), 2);
        chk("alu_sb", int'(SB), 3);
        chk("alu_rw", int'(RW), 1);
        @(negedge clk_main);
        chk("alu_rw_off", int'(RW), 0);
        @(negedge clk_main);
        chk("alu_pc2", int'(PC), 2);

        // LDI
        @(negedge clk_main);
        rst_assert(2);
        fill_nop();
        imem[0] = 16'hC40A;
        imem[1] = 16'hFF00;
        rst_release();
        @(negedge clk_main);
        chk("ldi_mb", int'(MB), 1);
        chk("ldi_const", int'(ConstOut), 16'h000A);
        chk("ldi_dr", int'(DR), 4);
        chk("ldi_rw", int'(RW), 1);
        @(negedge clk_main);
        chk("ldi_rw_off", int'(RW), 0);
        chk("ldi_mb_off", int'(MB), 0);

        // LD: three cycles
        @(negedge clk_main);
        rst_assert(3);
        fill_nop();
        imem[0] = 16'hD250;
        rst_release();
        @(negedge clk_main);
        chk("ld_rw", int'(RW), 0);
        chk("ld_sa", int'(SA), 5);
        @(negedge clk_main);
        chk("ld_md", int'(MD), 1);
        chk("ld_rw_wb", int'(RW), 1);
        chk("ld_dr", int'(DR), 2);
        chk("ld_pc_wb", int'(PC), 1);
        @(negedge clk_main);
        chk("ld_md_off", int'(MD), 0);
        chk("ld_rw_off", int'(RW), 0);

        // BZ taken / not taken from PC=10
        for (int zv = 1; zv >= 0; zv--) begin
            @(negedge clk_main);
            rst_assert(1);
            fill_nop();
            imem[0]  = 16'hF00A;
            imem[10] = 16'hF11E;
            imem[9]  = 16'hFF00;
            imem[11] = 16'hFF00;
            z_force  = 1'b1;
            z_val    = zv[0];
            rst_release();
            @(negedge clk_main);
            @(negedge clk_main);
            chk("bz_pc_fetch", int'(PC), 10);
            @(negedge clk_main);
            chk("bz_pc_exec", int'(PC), 11);
            chk("bz_fs", int'(FS), 0);
            chk("bz_sa", int'(SA), 1);
            @(negedge clk_main);
            chk("bz_pc_after", int'(PC), (zv == 1) ? 9 : 11);
        end
        z_force = 1'b0;

        // PC wrap 63 -> 0
        @(negedge clk_main);
        rst_assert(2);
        fill_nop();
        imem[0]  = 16'hF03F;
        imem[63] = 16'h0123;
        rst_release();
        @(negedge clk_main);
        @(negedge clk_main);
        chk("wrap_pc63", int'(PC), 63);
        @(negedge clk_main);
        chk("wrap_pc0", int'(PC), 0);

        // HLT: frozen for 20 cycles
        @(negedge clk_main);
        rst_assert(2);
        fill_nop();
        imem[0] = 16'hFF00;
        rst_release();
        @(negedge clk_main);
        @(negedge clk_main);
        for (int i = 0; i < 20; i++) begin
            chk("hlt_halted", int'(halted), 1);
            chk("hlt_pc", int'(PC), 1);
            chk("hlt_rw", int'(RW), 0);
            chk("hlt_mw", int'(MW), 0);
            @(negedge clk_main);
        end

        // Async reset during ST execute
        rst_assert(2);
        fill_nop();
        imem[0] = 16'hE123;
        imem[1] = 16'hFF00;
        rst_release();
        @(negedge clk_main);
        chk("st_mw", int'(MW), 1);
        chk("st_rw", int'(RW), 0);
        rst_assert(2);
        chk("st_abort_mw", int'(MW), 0);

        // Randomized programs, each ended by an asynchronous reset
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 64; i++) begin
                imem[i] = 16'($urandom);
                if (imem[i][15:8] == 8'hFF && $urandom_range(0, 3) != 0)
                    imem[i][11:8] = 4'h3;
            end
            rst_release();
            repeat ($urandom_range(40, 300)) @(negedge clk_main);
            rst_assert($urandom_range(1, 3));
        end

        @(negedge clk_main);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
